// File: rtl/pattern_det_ctrl_if.sv
// Bus bundle for pattern_det_ctrl: configuration, run control, serial data and status.
interface pattern_det_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic             cfg_we;
  logic [7:0]       cfg_pattern;
  logic [2:0]       cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_limit;
  logic             start;
  logic             stop;
  logic             din;
  logic             din_valid;
  logic             detect;
  logic [CNT_W-1:0] match_count;
  logic             busy;
  logic             done;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_limit,
    output start, stop, din, din_valid,
    input  detect, match_count, busy, done
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_limit,
    input  start, stop, din, din_valid,
    output detect, match_count, busy, done
  );
endinterface

// File: rtl/pattern_det_ctrl.sv
// Serial bit-pattern detector with configurable length/overlap, a saturating
// match counter and an optional match limit that parks the run in DONE.
module pattern_det_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  pattern_det_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [7:0]       pat_r;
  logic [2:0]       len_r;
  logic             ovl_r;
  logic [CNT_W-1:0] lim_r;
  logic [CNT_W-1:0] cnt_r, cnt_inc;
  logic [7:0]       hist, hist_n, mask;
  logic [3:0]       fill, fill_inc, fill_n, len_p1;
  logic             accept, match, limit_hit, start_run;
  logic             detect_r, busy_r, done_r;

  // A stop in the same cycle suppresses acceptance, so it also discards any match.
  always_comb begin
    hist_n    = {hist[6:0], bus.din};
    len_p1    = {1'b0, len_r} + 4'd1;
    fill_inc  = fill + 4'd1;
    fill_n    = (fill_inc > len_p1) ? len_p1 : fill_inc;
    mask      = 8'hFF >> (3'd7 - len_r);
    accept    = (state == RUN) && bus.din_valid && !bus.stop;
    match     = accept && (fill_n == len_p1) && (((hist_n ^ pat_r) & mask) == '0);
    cnt_inc   = (&cnt_r) ? cnt_r : cnt_r + CNT_W'(1);
    limit_hit = (lim_r != '0) && (cnt_inc == lim_r);
  end

  always_comb begin
    state_n   = state;
    start_run = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_n   = RUN;
          start_run = 1'b1;
        end
      end
      RUN: begin
        if (bus.stop)
          state_n = IDLE;
        else if (match && limit_hit)
          state_n = DONE;
      end
      DONE: begin
        if (bus.stop) begin
          state_n = IDLE;
        end else if (bus.start) begin
          state_n   = RUN;
          start_run = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r    <= 8'b0000_0101;
      len_r    <= 3'd2;
      ovl_r    <= 1'b1;
      lim_r    <= '0;
      cnt_r    <= '0;
      hist     <= '0;
      fill     <= '0;
      detect_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      if (state == IDLE && bus.cfg_we) begin
        pat_r <= bus.cfg_pattern;
        len_r <= bus.cfg_len;
        ovl_r <= bus.cfg_overlap;
        lim_r <= bus.cfg_limit;
      end
      detect_r <= match;
      busy_r   <= (state_n == RUN);
      done_r   <= (state_n == DONE);
      if (start_run) begin
        cnt_r <= '0;
        hist  <= '0;
        fill  <= '0;
      end else if (accept) begin
        hist <= hist_n;
        fill <= (match && !ovl_r) ? 4'd0 : fill_n;
        if (match)
          cnt_r <= cnt_inc;
      end
    end
  end

  assign bus.detect      = detect_r;
  assign bus.match_count = cnt_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
endmodule

// File: tb/tb_pattern_det_ctrl.sv
// Bench for pattern_det_ctrl: fixed vector table, directed corner sequences and
// random traffic, all checked against a queue-based reference model.
module tb_pattern_det_ctrl;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  typedef struct {
    logic       rst, cfg_we;
    logic [7:0] pat;
    logic [2:0] len;
    logic       ovl;
    logic [7:0] lim;
    logic       start, stop, din, dv;
  } in_t;

  typedef struct {
    in_t         i;
    logic        det;
    int unsigned cnt;
    logic        busy, done;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pattern_det_ctrl_if #(.CNT_W(CNT_W)) bus ();
  pattern_det_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: mode 0=idle 1=run 2=done; q holds bits received since the last clear.
  int          m_mode = 0;
  bit          m_q[$];
  logic [7:0]  m_pat  = 8'd5;
  int          m_len  = 3;
  bit          m_ovl  = 1;
  int unsigned m_lim  = 0;
  int unsigned m_cnt  = 0;
  bit          m_det  = 0;

  function automatic bit tail_eq();
    if (m_q.size() < m_len) return 0;
    for (int i = 0; i < m_len; i++)
      if (m_q[m_q.size() - 1 - i] != m_pat[i]) return 0;
    return 1;
  endfunction

  function automatic void model(in_t x);
    if (x.rst) begin
      m_mode = 0; m_q.delete(); m_pat = 8'd5; m_len = 3; m_ovl = 1;
      m_lim = 0; m_cnt = 0; m_det = 0;
      return;
    end
    m_det = 0;
    case (m_mode)
      0: begin
        if (x.cfg_we) begin
          m_pat = x.pat; m_len = int'(x.len) + 1; m_ovl = x.ovl; m_lim = x.lim;
        end
        if (x.start && !x.stop) begin
          m_mode = 1; m_cnt = 0; m_q.delete();
        end
      end
      1: begin
        if (x.stop) m_mode = 0;
        else if (x.dv) begin
          m_q.push_back(x.din);
          if (m_q.size() > 8) void'(m_q.pop_front());
          if (tail_eq()) begin
            m_det = 1;
            if (m_cnt < CMAX) m_cnt++;
            if (!m_ovl) m_q.delete();
            if (m_lim != 0 && m_cnt == m_lim) m_mode = 2;
          end
        end
      end
      default: begin
        if (x.stop) m_mode = 0;
        else if (x.start) begin
          m_mode = 1; m_cnt = 0; m_q.delete();
        end
      end
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(in_t x);
    rst             = x.rst;
    bus.cfg_we      = x.cfg_we;
    bus.cfg_pattern = x.pat;
    bus.cfg_len     = x.len;
    bus.cfg_overlap = x.ovl;
    bus.cfg_limit   = x.lim;
    bus.start       = x.start;
    bus.stop        = x.stop;
    bus.din         = x.din;
    bus.din_valid   = x.dv;
    @(posedge clk);
    model(x);
    #1;
    chk("mdl_detect", {31'd0, bus.detect}, {31'd0, m_det});
    chk("mdl_count",  {24'd0, bus.match_count}, m_cnt);
    chk("mdl_busy",   {31'd0, bus.busy}, {31'd0, m_mode == 1});
    chk("mdl_done",   {31'd0, bus.done}, {31'd0, m_mode == 2});
  endtask

  function automatic in_t N();
    in_t x;
    x = '{rst: 0, cfg_we: 0, pat: 0, len: 0, ovl: 0, lim: 0, start: 0, stop: 0, din: 0, dv: 0};
    return x;
  endfunction
  function automatic in_t R();  in_t x = N(); x.rst = 1; return x; endfunction
  function automatic in_t S();  in_t x = N(); x.start = 1; return x; endfunction
  function automatic in_t P();  in_t x = N(); x.stop = 1; return x; endfunction
  function automatic in_t SP(); in_t x = N(); x.start = 1; x.stop = 1; return x; endfunction
  function automatic in_t B(bit b); in_t x = N(); x.dv = 1; x.din = b; return x; endfunction
  function automatic in_t C(logic [7:0] p, logic [2:0] l, bit o, logic [7:0] lm);
    in_t x = N();
    x.cfg_we = 1; x.pat = p; x.len = l; x.ovl = o; x.lim = lm;
    return x;
  endfunction
  function automatic vec_t V(in_t x, bit d, int unsigned c, bit b, bit dn);
    vec_t v;
    v.i = x; v.det = d; v.cnt = c; v.busy = b; v.done = dn;
    return v;
  endfunction

  vec_t tbl[$];
  in_t  x;

  initial begin
    rst = 1'b1;
    bus.cfg_we = 0; bus.cfg_pattern = 0; bus.cfg_len = 0; bus.cfg_overlap = 0;
    bus.cfg_limit = 0; bus.start = 0; bus.stop = 0; bus.din = 0; bus.din_valid = 0;

    // Default pattern 101, overlapping
    tbl.push_back(V(R(),  0, 0, 0, 0));
    tbl.push_back(V(S(),  0, 0, 1, 0));
    tbl.push_back(V(B(1), 0, 0, 1, 0));
    tbl.push_back(V(B(0), 0, 0, 1, 0));
    tbl.push_back(V(B(1), 1, 1, 1, 0));
    tbl.push_back(V(B(0), 0, 1, 1, 0));
    tbl.push_back(V(B(1), 1, 2, 1, 0));
    tbl.push_back(V(N(),  0, 2, 1, 0));
    tbl.push_back(V(P(),  0, 2, 0, 0));
    // Non-overlapping 101
    tbl.push_back(V(C(8'd5, 3'd2, 0, 8'd0), 0, 2, 0, 0));
    tbl.push_back(V(S(),  0, 0, 1, 0));
    tbl.push_back(V(B(1), 0, 0, 1, 0));
    tbl.push_back(V(B(0), 0, 0, 1, 0));
    tbl.push_back(V(B(1), 1, 1, 1, 0));
    tbl.push_back(V(B(0), 0, 1, 1, 0));
    tbl.push_back(V(B(1), 0, 1, 1, 0));
    tbl.push_back(V(P(),  0, 1, 0, 0));
    // Limit of 2 ends the run in DONE
    tbl.push_back(V(C(8'd5, 3'd2, 1, 8'd2), 0, 1, 0, 0));
    tbl.push_back(V(S(),  0, 0, 1, 0));
    tbl.push_back(V(B(1), 0, 0, 1, 0));
    tbl.push_back(V(B(0), 0, 0, 1, 0));
    tbl.push_back(V(B(1), 1, 1, 1, 0));
    tbl.push_back(V(B(0), 0, 1, 1, 0));
    tbl.push_back(V(B(1), 1, 2, 0, 1));
    tbl.push_back(V(B(0), 0, 2, 0, 1));
    tbl.push_back(V(B(1), 0, 2, 0, 1));
    tbl.push_back(V(SP(), 0, 2, 0, 0));

    foreach (tbl[k]) begin
      step(tbl[k].i);
      chk($sformatf("tbl%0d_detect", k), {31'd0, bus.detect}, {31'd0, tbl[k].det});
      chk($sformatf("tbl%0d_count", k),  {24'd0, bus.match_count}, tbl[k].cnt);
      chk($sformatf("tbl%0d_busy", k),   {31'd0, bus.busy}, {31'd0, tbl[k].busy});
      chk($sformatf("tbl%0d_done", k),   {31'd0, bus.done}, {31'd0, tbl[k].done});
    end

    // Config write during RUN is ignored
    step(R()); step(S());
    step(C(8'hFF, 3'd2, 1, 8'd0));
    for (int i = 0; i < 3; i++) begin
      step(B(1));
      chk("cfg_ign_no_detect", {31'd0, bus.detect}, 32'd0);
    end
    step(B(0)); step(B(1));
    chk("cfg_ign_detect", {31'd0, bus.detect}, 32'd1);
    chk("cfg_ign_count", {24'd0, bus.match_count}, 32'd1);

    // Reset alongside an accepted matching bit
    step(R()); step(S()); step(B(1)); step(B(0));
    x = B(1); x.rst = 1;
    step(x);
    chk("rst_mid_detect", {31'd0, bus.detect}, 32'd0);
    chk("rst_mid_count",  {24'd0, bus.match_count}, 32'd0);
    chk("rst_mid_busy",   {31'd0, bus.busy}, 32'd0);
    chk("rst_mid_done",   {31'd0, bus.done}, 32'd0);
    step(N());
    chk("rst_after_detect", {31'd0, bus.detect}, 32'd0);

    // Saturation with single-bit pattern, no limit
    step(C(8'd1, 3'd0, 1, 8'd0)); step(S());
    for (int i = 0; i < 300; i++) begin
      step(B(1));
      chk("sat_detect", {31'd0, bus.detect}, 32'd1);
      chk("sat_count", {24'd0, bus.match_count}, (i + 1 < CMAX) ? i + 1 : CMAX);
    end
    chk("sat_busy", {31'd0, bus.busy}, 32'd1);

    // Random traffic
    step(R());
    for (int i = 0; i < 3000; i++) begin
      x = N();
      x.rst    = ($urandom_range(0, 199) == 0);
      x.cfg_we = ($urandom_range(0, 7) == 0);
      x.pat    = 8'($urandom);
      x.len    = 3'($urandom_range(0, 3));
      x.ovl    = 1'($urandom);
      x.lim    = 8'($urandom_range(0, 4));
      x.start  = ($urandom_range(0, 9) == 0);
      x.stop   = ($urandom_range(0, 39) == 0);
      x.dv     = ($urandom_range(0, 3) != 0);
      x.din    = 1'($urandom);
      step(x);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pattern_det_ctrl.md
PATTERN_DET_CTRL -- requirements
Module: pattern_det_ctrl

Interface
REQ-001 Parameter CNT_W, default 8: width of the match counter and the limit register.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 cfg_we  input  1  configuration write strobe; accepted only in IDLE.
REQ-005 cfg_pattern  input  8  pattern to detect; bit 0 is the most recently received bit.
REQ-006 cfg_len  input  3  pattern length minus 1 (0..7 means length 1..8).
REQ-007 cfg_overlap  input  1  1 = overlapping matches allowed; 0 = history flushed after each match.
REQ-008 cfg_limit  input  CNT_W  match count that ends the run; 0 = unlimited.
REQ-009 start  input  1  single-cycle pulse that begins a run from IDLE or DONE.
REQ-010 stop  input  1  single-cycle pulse that aborts to IDLE.
REQ-011 din  input  1  serial data bit.
REQ-012 din_valid  input  1  din is sampled only when this is 1.
REQ-013 detect  output  1  one-cycle pulse on each match.
REQ-014 match_count  output  CNT_W  matches in the current run; saturates at all-ones.
REQ-015 busy  output  1  1 while in RUN.
REQ-016 done  output  1  1 while in DONE.

Function
REQ-017 States: IDLE, RUN, DONE; encoding is free.
REQ-018 The block SHALL hold internal registers pat_r, len_r, ovl_r and lim_r, plus an 8-bit history hist and a 4-bit fill count fill.
REQ-019 In IDLE with cfg_we=1, the config registers SHALL load from the cfg_* inputs on the next edge.
REQ-020 In RUN or DONE, cfg_we SHALL be ignored.
REQ-021 IDLE to RUN on start=1 and stop=0: match_count, hist and fill SHALL be cleared on the same edge.
REQ-022 RUN behaviour when din_valid=1:
- hist_n = {hist[6:0], din}
- fill_n = min(fill+1, len_r+1)
REQ-023 A match SHALL be declared when both hold:
- fill_n == len_r+1
- hist_n[len_r:0] == pat_r[len_r:0]
REQ-024 On a match:
- detect=1 in the following cycle (latency 1 from the accepting edge)
- match_count increments, saturating at 2^CNT_W-1
REQ-025 On a match with ovl_r=0, fill SHALL be cleared to 0 instead of taking fill_n.
REQ-026 In RUN with din_valid=0, hist, fill and match_count SHALL hold.
REQ-027 In RUN with lim_r!=0, a match that brings match_count to lim_r SHALL move the FSM to DONE on that same edge.
REQ-028 In DONE, din SHALL be ignored and detect SHALL stay 0.
REQ-029 In DONE, match_count SHALL hold until the next start.
REQ-030 In DONE, start moves to RUN with the same clearing as REQ-021; stop moves to IDLE.
REQ-031 In RUN, stop=1 SHALL move the FSM to IDLE on the next edge.
REQ-032 A stop SHALL discard any match on that same edge: no detect and no count increment.
REQ-033 The match_count value is kept after a stop.
REQ-034 If start and stop are both 1 in the same cycle, stop SHALL win.
REQ-035 start while in RUN SHALL be ignored.
REQ-036 Once saturated, match_count SHALL stay at all-ones while detect keeps pulsing; with lim_r=0 the run continues.
REQ-037 busy and done SHALL be registered decodes of the state.
REQ-038 No combinational path SHALL exist from any input to any output.

Reset
REQ-039 On rst=1 at a clock edge, the block SHALL be forced to IDLE with all of the following:
- detect=0, busy=0, done=0, match_count=0
- hist=0, fill=0
- pat_r=8'b101, len_r=2, ovl_r=1, lim_r=0
REQ-040 rst SHALL override start, stop, cfg_we and din_valid in the same cycle.
REQ-041 An rst during RUN SHALL abort the run with no detect pulse in the cycle after.

Verification
REQ-042 Default config after reset; start; din=1,0,1,0,1 on consecutive valid cycles -> detect pulses after the 3rd and 5th bits; match_count=2; busy=1.
REQ-043 cfg_overlap=0, cfg_len=2, cfg_pattern=101; same stream -> one detect after the 3rd bit; match_count=1.
REQ-044 cfg_limit=2, overlap=1; stream 1,0,1,0,1,0,1:
- done=1 the cycle after the 5th bit; busy=0; match_count=2
- the 7th bit produces no detect
REQ-045 cfg_we with pattern 8'hFF while in RUN -> ignored; stream 1,1,1 -> no detect; default 101 still detects.
REQ-046 rst asserted mid-run, in the same cycle as an accepted matching bit -> next cycle detect=0, match_count=0, busy=0, state IDLE.
REQ-047 CNT_W=8, cfg_len=0, cfg_pattern=1, limit 0; 300 valid 1 bits -> match_count=255, detect pulses on all 300 bits, busy=1.
